ctrl_pipe_ewm: RTL

- Carries decode-stage control bundle (output of main controller) through the D/E, E/M and M/W pipeline registers of the 5-stage RISC-V core.
- Resolves branch/jump in Execute from registered branch/jump codes plus ALU flags; drives PC-select to fetch.
- Supplies per-stage control to the hazard unit, ALU, data memory and writeback mux.
- Owns all control-path pipeline state; the datapath registers are separate.

---
 rtl/ctrl_pipe_ewm.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_ewm.sv
// Control-path pipeline registers D/E, E/M and M/W for the 5-stage RISC-V core,
// plus Execute-stage branch/jump resolution driving the fetch PC select.
module ctrl_pipe_ewm (
  input  logic       clk,
  input  logic       rst,
  input  logic       flushE,
  input  logic       regWriteD,
  input  logic       memWriteD,
  input  logic       ALUSrcD,
  input  logic       luiD,
  input  logic [1:0] resultSrcD,
  input  logic [1:0] jumpD,
  input  logic [1:0] ALUOpD,
  input  logic [2:0] branchD,
  input  logic       zeroE,
  input  logic       ltE,
  output logic       regWriteE,
  output logic       ALUSrcE,
  output logic       luiE,
  output logic [1:0] resultSrcE,
  output logic [1:0] ALUOpE,
  output logic [1:0] pcSrcE,
  output logic       regWriteM,
  output logic       memWriteM,
  output logic [1:0] resultSrcM,
  output logic       regWriteW,
  output logic [1:0] resultSrcW
);

  localparam int unsigned RS_W  = 2;
  localparam int unsigned JMP_W = 2;
  localparam int unsigned AOP_W = 2;
  localparam int unsigned BR_W  = 3;

  localparam logic [JMP_W-1:0] JMP_JAL  = JMP_W'(2'b01);
  localparam logic [JMP_W-1:0] JMP_JALR = JMP_W'(2'b10);

  localparam logic [BR_W-1:0] BR_BEQ = BR_W'(3'b001);
  localparam logic [BR_W-1:0] BR_BNE = BR_W'(3'b010);
  localparam logic [BR_W-1:0] BR_BLT = BR_W'(3'b011);
  localparam logic [BR_W-1:0] BR_BGE = BR_W'(3'b100);

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  typedef struct packed {
    logic             regwrite;
    logic             memwrite;
    logic             alusrc;
    logic             lui;
    logic [RS_W-1:0]  resultsrc;
    logic [JMP_W-1:0] jump;
    logic [AOP_W-1:0] aluop;
    logic [BR_W-1:0]  branch;
  } de_t;

  de_t             de_d;
  de_t             de_q;
  logic            regwrite_m;
  logic            memwrite_m;
  logic [RS_W-1:0] resultsrc_m;
  logic            regwrite_w;
  logic [RS_W-1:0] resultsrc_w;
  logic            taken;

  always_comb begin
    de_d           = '0;
    de_d.regwrite  = regWriteD;
    de_d.memwrite  = memWriteD;
    de_d.alusrc    = ALUSrcD;
    de_d.lui       = luiD;
    de_d.resultsrc = resultSrcD;
    de_d.jump      = jumpD;
    de_d.aluop     = ALUOpD;
    de_d.branch    = branchD;
  end

  // D/E: a flush loads an all-zero bubble that can never write anything downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         de_q <= '0;
    else if (flushE) de_q <= '0;
    else             de_q <= de_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= '0;
      regwrite_w  <= 1'b0;
      resultsrc_w <= '0;
    end else begin
      regwrite_m  <= de_q.regwrite;
      memwrite_m  <= de_q.memwrite;
      resultsrc_m <= de_q.resultsrc;
      regwrite_w  <= regwrite_m;
      resultsrc_w <= resultsrc_m;
    end
  end

  // Unused branch codes 101..111 resolve as not taken
  always_comb begin
    taken = 1'b0;
    case (de_q.branch)
      BR_BEQ:  taken = zeroE;
      BR_BNE:  taken = ~zeroE;
      BR_BLT:  taken = ltE;
      BR_BGE:  taken = ~ltE;
      default: taken = 1'b0;
    endcase
  end

  // Depends only on E registers and ALU flags, so the hazard unit may derive flushE from it
  always_comb begin
    pcSrcE = PC_PLUS4;
    if (de_q.jump == JMP_JALR)                 pcSrcE = PC_ALU;
    else if ((de_q.jump == JMP_JAL) || taken)  pcSrcE = PC_IMM;
  end

  assign regWriteE  = de_q.regwrite;
  assign ALUSrcE    = de_q.alusrc;
  assign luiE       = de_q.lui;
  assign resultSrcE = de_q.resultsrc;
  assign ALUOpE     = de_q.aluop;
  assign regWriteM  = regwrite_m;
  assign memWriteM  = memwrite_m;
  assign resultSrcM = resultsrc_m;
  assign regWriteW  = regwrite_w;
  assign resultSrcW = resultsrc_w;

endmodule
